// File: rtl/siso_seq_ctrl_pkg.sv
// siso_seq_ctrl_pkg -- shared definitions for the serializer controller.
// Holds the FSM state encoding so the RTL and the testbench agree on it.
package siso_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/siso_seq_ctrl_if.sv
// siso_seq_ctrl_if -- word-in / serial-out bus of the serializer.
//   in_valid/in_ready/din : parallel word handshake (producer -> serializer)
//   hold                  : pause request while high
//   so/so_valid           : serial bit and its qualifier
//   busy/done             : status (not idle / one-cycle end-of-frame pulse)
// Modports: master = producer/observer side, slave = serializer side.
interface siso_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic             hold;
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, din, hold,
        input  in_ready, so, so_valid, busy, done
    );

    modport slave (
        input  in_valid, din, hold,
        output in_ready, so, so_valid, busy, done
    );
endinterface

// File: rtl/siso_shift_reg.sv
// siso_shift_reg -- loadable shift register with serial output.
//   clk, rst      : clock, asynchronous active-low reset (clears register)
//   load          : capture load_val (has priority over shift_en)
//   shift_en      : advance one bit towards the serial output
//   load_val [DW] : parallel value to capture
//   ser           : current serial bit (bit 0 if LSB_FIRST, else bit DW-1)
module siso_shift_reg #(
    parameter int DW        = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          shift_en,
    input  logic [DW-1:0] load_val,
    output logic          ser
);
    logic [DW-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= LSB_FIRST ? {1'b0, q[DW-1:1]} : {q[DW-2:0], 1'b0};
        end
    end

    assign ser = LSB_FIRST ? q[0] : q[DW-1];
endmodule

// File: rtl/siso_seq_ctrl.sv
// siso_seq_ctrl -- parallel-to-serial frame sequencer.
//   clk  : clock, all state changes on rising edge
//   rst  : asynchronous active-low reset
//   bus  : siso_seq_ctrl_if slave (in_valid/in_ready/din/hold in,
//          so/so_valid/busy/done out)
// Parameters: WIDTH data bits per frame (2..32), LSB_FIRST bit order.
// Optional feature: define SISO_SEQ_PARITY_EN to append an even-parity bit
// (XOR of din) after the data bits, giving WIDTH+1 bit frames.
module siso_seq_ctrl
    import siso_seq_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic           clk,
    input logic           rst,
    siso_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef SISO_SEQ_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    logic [FRAME-1:0] load_val;
    // Parity sits on the far end of the register so it leaves after the data.
    assign load_val = LSB_FIRST ? {^bus.din, bus.din} : {bus.din, ^bus.din};
`else
    localparam int FRAME = WIDTH;
    logic [FRAME-1:0] load_val;
    assign load_val = bus.din;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic          last;
    logic          load, shift_en, ser;
    logic          in_ready, so_valid, busy, done;

    // cnt indexes the bit currently on so; it stops at FRAME-1 so it never wraps.
    assign last = (cnt == CW'(FRAME - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cnt <= '0;
            end else if (shift_en && !last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        so_valid = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus.hold) begin
                    so_valid = 1'b1;
                    shift_en = 1'b1;
                    if (last) state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    siso_shift_reg #(
        .DW        (FRAME),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .load_val (load_val),
        .ser      (ser)
    );

    assign bus.in_ready = in_ready;
    assign bus.so_valid = so_valid;
    assign bus.so       = so_valid & ser;
    assign bus.busy     = busy;
    assign bus.done     = done;
endmodule

// File: tb/tb_siso_seq_ctrl.sv
// tb_siso_seq_ctrl -- directed bench for siso_seq_ctrl (WIDTH=8).
// Two instances: LSB-first and MSB-first. A vector table drives whole
// frames; reset-mid-frame is a hand-written sequence.
module tb_siso_seq_ctrl;
    import siso_seq_ctrl_pkg::*;

`ifdef SISO_SEQ_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    siso_seq_ctrl_if #(.WIDTH(8)) ifl ();
    siso_seq_ctrl_if #(.WIDTH(8)) ifm ();

    siso_seq_ctrl #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (ifl.slave)
    );

    siso_seq_ctrl #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (ifm.slave)
    );

    logic sel_msb;
    logic o_so, o_so_valid, o_in_ready, o_busy, o_done;
    assign o_so       = sel_msb ? ifm.so       : ifl.so;
    assign o_so_valid = sel_msb ? ifm.so_valid : ifl.so_valid;
    assign o_in_ready = sel_msb ? ifm.in_ready : ifl.in_ready;
    assign o_busy     = sel_msb ? ifm.busy     : ifl.busy;
    assign o_done     = sel_msb ? ifm.done     : ifl.done;

    int checks   = 0;
    int failures = 0;

    // seq: expected serial bits in emission order, first bit at seq[7].
    typedef struct {
        logic [7:0] din;
        bit         msb;
        bit         churn;
        int         hold_after;
        int         hold_len;
        logic [7:0] seq;
        bit         par;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic h);
        if (sel_msb) begin
            ifm.in_valid = v; ifm.din = d; ifm.hold = h;
            ifl.in_valid = 1'b0; ifl.din = '0; ifl.hold = 1'b0;
        end else begin
            ifl.in_valid = v; ifl.din = d; ifl.hold = h;
            ifm.in_valid = 1'b0; ifm.din = '0; ifm.hold = 1'b0;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered just after a rising edge with the selected DUT idle.
    task automatic run_frame(input vec_t v);
        int   got;
        int   hcnt;
        int   done_at;
        logic h;
        logic expb;
        got = 0; hcnt = 0; done_at = 0;
        sel_msb = v.msb;
        drive(1'b1, v.din, 1'b0);
        #1;
        chk("idle_ready", {31'd0, o_in_ready}, 32'd1);
        chk("idle_busy", {31'd0, o_busy}, 32'd0);
        tick;
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            h = (got == v.hold_after) && (hcnt < v.hold_len);
            if (h) hcnt++;
            drive(v.churn, v.churn ? 8'($urandom) : 8'h00, h);
            #1;
            if (o_done) begin
                done_at = c;
            end else begin
                chk("shift_ready", {31'd0, o_in_ready}, 32'd0);
                chk("shift_busy", {31'd0, o_busy}, 32'd1);
                if (h) chk("hold_sv", {31'd0, o_so_valid}, 32'd0);
                if (o_so_valid) begin
                    if (got < 8) expb = v.seq[7 - got];
                    else         expb = v.par;
                    if (got < NBITS) chk("so_bit", {31'd0, o_so}, {31'd0, expb});
                    got++;
                end else begin
                    chk("so_zero", {31'd0, o_so}, 32'd0);
                end
                tick;
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        if (done_at == 0) $display("FAIL frame_timeout: got no done expected done");
        chk("done_ready", {31'd0, o_in_ready}, 32'd0);
        chk("done_sv", {31'd0, o_so_valid}, 32'd0);
        chk("bit_count", 32'(got), 32'(NBITS));
        chk("done_cycle", 32'(done_at), 32'(NBITS + v.hold_len + 1));
        tick;
        #1;
        chk("post_done", {31'd0, o_done}, 32'd0);
        chk("post_ready", {31'd0, o_in_ready}, 32'd1);
        chk("post_busy", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, ifl.in_ready}, 32'd1);
        chk({tag, "_so"}, {31'd0, ifl.so}, 32'd0);
        chk({tag, "_sv"}, {31'd0, ifl.so_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, ifl.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, ifl.done}, 32'd0);
        chk({tag, "_state"}, {30'd0, dut_l.state_q}, {30'd0, IDLE});
        chk({tag, "_cnt"}, 32'(dut_l.cnt), 32'd0);
    endtask

    initial begin
        int   got;
        logic saw_done;

        //            din    msb churn hafter hlen seq          par
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 0, 0, 8'b1010_0101, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 0, 0, 8'b1010_0101, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 0, 0, 8'b0000_0001, 1'b1};
        vecs[3] = '{8'h01, 1'b0, 1'b0, 0, 0, 8'b1000_0000, 1'b1};
        vecs[4] = '{8'hF0, 1'b0, 1'b0, 2, 3, 8'b0000_1111, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 7, 2, 8'b0011_1100, 1'b0};
        vecs[6] = '{8'h07, 1'b0, 1'b0, 0, 0, 8'b1110_0000, 1'b1};
        vecs[7] = '{8'hF0, 1'b1, 1'b1, 0, 0, 8'b1111_0000, 1'b0};
        vecs[8] = '{8'h80, 1'b0, 1'b1, 0, 1, 8'b0000_0001, 1'b1};

        sel_msb = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("reset");
        tick;
        tick;
        rst = 1'b1;

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset after the 4th bit of 8'hFF: immediate return to reset values,
        // no done pulse, then a clean 8'h3C frame.
        sel_msb = 1'b0;
        got = 0;
        drive(1'b1, 8'hFF, 1'b0);
        tick;
        drive(1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 10 && got < 4; c++) begin
            #1;
            if (o_so_valid) got++;
            tick;
        end
        chk("pre_reset_bits", 32'(got), 32'd4);
        chk("pre_reset_state", {30'd0, dut_l.state_q}, {30'd0, SHIFT});
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) rst = 1'b1;
            tick;
            if (ifl.done) saw_done = 1'b1;
        end
        chk("midrst_no_done", {31'd0, saw_done}, 32'd0);
        run_frame('{8'h3C, 1'b0, 1'b0, 0, 0, 8'b0011_1100, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
